// File: rtl/imem_responder.sv
// -----------------------------------------------------------------------------
// imem_responder
//
// Instruction-memory responder for the fetch stage. A DEPTH x 32-bit storage
// array is read through a LATENCY-stage pipeline. A separate word-write load
// port fills the array, so programs come from boot logic or a bench and not
// from file reads.
//
// Handshake semantics (both channels):
//   A transfer happens on a rising edge where valid && ready are both high.
//   A producer that raises valid holds it and its payload until that edge.
//   The request side has ready = advance && !load_en && !flush, computed
//   combinationally. The response side stalls the whole pipeline while
//   rsp_valid && !rsp_ready.
//
// Ports:
//   clk        - single clock, all logic on the rising edge
//   rst        - asynchronous active-low reset (clears pipeline, not memory)
//   req_valid  - fetch request present
//   req_ready  - request accepted on an edge with req_valid && req_ready
//   req_addr   - byte address of the instruction
//   rsp_valid  - response present (last pipeline stage valid)
//   rsp_ready  - consumer takes the response; low means stall
//   rsp_instr  - instruction word (zero / NOP on error)
//   rsp_addr   - byte address the response belongs to
//   rsp_err    - address misaligned or beyond the array
//   flush      - discard every in-flight entry at the next edge
//   load_en    - write load_data to mem[load_addr]
//   load_addr  - word index for the load
//   load_data  - word to store
//   busy       - at least one pipeline stage holds a valid entry
//
// LATENCY must be in 1..4; DEPTH must be a power of two.
// -----------------------------------------------------------------------------
module imem_responder #(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [31:0]       req_addr,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_instr,
  output logic [31:0]       rsp_addr,
  output logic              rsp_err,
  input  logic              flush,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [31:0]       load_data,
  output logic              busy
);

  // Storage array: never reset, contents defined only by loads.
  logic [31:0] mem [DEPTH];

  // Pipeline stages; index 0 is the capture stage, LATENCY-1 drives rsp_*.
  logic [LATENCY-1:0] st_valid;
  logic [LATENCY-1:0] st_err;
  logic [31:0]        st_addr  [LATENCY];
  logic [31:0]        st_instr [LATENCY];

  logic              advance;
  logic              accept;
  logic              req_err;
  logic [ADDR_W-1:0] req_idx;

  // The pipeline only holds when the last stage has a response nobody takes.
  // An empty last stage lets everything move up, collapsing bubbles.
  assign advance   = !(rsp_valid && !rsp_ready);
  assign req_ready = advance && !load_en && !flush;
  assign accept    = req_valid && req_ready;

  // Word index and address-range check. Any upper bit beyond the array
  // flags an error.
  assign req_err = (req_addr[1:0] != 2'b00) || (req_addr[31:ADDR_W+2] != '0);
  assign req_idx = req_addr[ADDR_W+1:2];

  always_ff @(posedge clk) begin
    if (load_en) begin
      mem[load_addr] <= load_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st_valid <= '0;
      st_err   <= '0;
      for (int k = 0; k < LATENCY; k++) begin
        st_addr[k]  <= '0;
        st_instr[k] <= '0;
      end
    end else if (flush) begin
      // Flush beats both shifting and the stall hold. Data are left stale
      // because nothing reads them without a valid bit.
      st_valid <= '0;
    end else if (advance) begin
      // Stage 0 becomes a bubble when nothing is accepted.
      st_valid[0] <= accept;
      if (accept) begin
        st_addr[0]  <= req_addr;
        st_err[0]   <= req_err;
        st_instr[0] <= req_err ? 32'h0000_0000 : mem[req_idx];
      end
      for (int k = 1; k < LATENCY; k++) begin
        st_valid[k] <= st_valid[k-1];
        st_err[k]   <= st_err[k-1];
        st_addr[k]  <= st_addr[k-1];
        st_instr[k] <= st_instr[k-1];
      end
    end
  end

  assign rsp_valid = st_valid[LATENCY-1];
  assign rsp_err   = st_err[LATENCY-1];
  assign rsp_addr  = st_addr[LATENCY-1];
  assign rsp_instr = st_instr[LATENCY-1];
  assign busy      = |st_valid;

endmodule

// File: doc/imem_responder.md
# imem_responder

Instruction-memory responder serving the fetch stage's read requests over a valid/ready handshake, with a fixed-latency read pipeline. It also provides a word-write load port, so programs are loaded by the bench or boot logic instead of by simulation file reads. The fetch stage holds `rsp_ready` low during hazard stalls and pulses `flush` on a taken-branch redirect. The block sits between the fetch stage and the instruction storage array.

## Interface
- `DEPTH`, 1024: memory size in 32-bit words; power of two; `ADDR_W = log2(DEPTH)`.
- `LATENCY`, 2: cycles from request acceptance to `rsp_valid`; legal range 1..4.
- `clk` in 1: single clock; all logic on the rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `req_valid` in 1: fetch request present.
- `req_ready` out 1: request accepted on an edge where `req_valid && req_ready`.
- `req_addr` in 32: byte address of the instruction.
- `rsp_valid` out 1: response present.
- `rsp_ready` in 1: consumer takes the response; low means stall.
- `rsp_instr` out 32: instruction word.
- `rsp_addr` out 32: byte address the response belongs to.
- `rsp_err` out 1: address misaligned or out of range.
- `flush` in 1: discard all in-flight responses.
- `load_en` in 1: write `load_data` to the memory.
- `load_addr` in ADDR_W: word index for the load.
- `load_data` in 32: word to store.
- `busy` out 1: at least one pipeline stage holds a valid entry.

## Operation
- The storage array is `DEPTH` x 32 bits and is not reset. Its contents are defined only by loads.
- `load_en` writes `mem[load_addr] <= load_data` at the edge. While `load_en` is high, `req_ready` is 0, so a read and a load never occur in the same cycle.
- The pipeline has `LATENCY` stages. Each stage holds valid, addr, instr and err.
- The `advance` condition is `!(rsp_valid && !rsp_ready)`. All stages shift together when `advance` is true. When it is false, every stage holds its contents.
- `req_ready = advance && !load_en && !flush`, computed combinationally.
- On acceptance, stage 1 captures the following:
  - `addr`.
  - `err = (addr[1:0] != 0) || (addr[31:ADDR_W+2] != 0)`.
  - `instr = err ? 32'h0000_0000 : mem[addr[ADDR_W+1:2]]`. This is a synchronous read, and the all-zero word is the NOP encoding.
- If stage 1 advances with no acceptance, its valid bit is cleared (a bubble).
- The last stage drives `rsp_valid`, `rsp_instr`, `rsp_addr` and `rsp_err`.
- When `rsp_valid` is 0, the data outputs are don't-care. The bench must not check them.
- `flush` clears every stage valid bit at the next edge. This takes priority over shifting and over the hold caused by a stall. A request presented in the flush cycle is not accepted.
- `busy` is the OR of all stage valid bits.

## Timing
- Reset (`rst` low) takes effect immediately, without waiting for a clock edge. All valid bits clear, so `rsp_valid = 0` and `busy = 0`. `rsp_instr`, `rsp_addr` and `rsp_err` go to 0. Memory contents are preserved.
- Reset asserted mid-operation drops all in-flight responses. No response appears after reset for requests accepted before it.
- Latency: a request accepted at edge N produces `rsp_valid` from just after edge N+LATENCY-1 until the edge at which `rsp_ready` is sampled high. With `LATENCY = 1`, `rsp_valid` is high in the cycle after acceptance.
- Throughput is one request per cycle while `rsp_ready` stays high.
- Under a stall (`rsp_valid=1`, `rsp_ready=0`), the outputs hold stable and `req_ready = 0`. No entries are lost or duplicated.
- If the last stage is empty, the pipeline advances even when `rsp_ready = 0`, so internal bubbles are collapsed.
- Simultaneous events:
  - `flush` with a stall: flush wins.
  - `flush` with `load_en`: both act (the write happens, the pipeline clears).
  - `load_en` with `req_valid`: the load happens and the request waits.
- A load to address A at edge N is visible to a request accepted at edge N+1 or later.

## Test plan
- Load `mem[0..3] = 0x20010005, 0x20020007, 0x00221820, 0x08000000`. Request addresses 0, 4, 8, 12 back-to-back with `rsp_ready=1` and `LATENCY=2`. Required: `rsp_valid` on four consecutive cycles with those words and matching `rsp_addr`.
- Accept addr 0 and 4, then hold `rsp_ready=0` for 3 cycles. Required: `rsp_instr = 0x20010005` stays stable, `req_ready = 0`, and after release 0x20010005 then 0x20020007 each appear exactly once.
- With 2 requests in flight, assert `flush` for one cycle together with `req_valid` on addr 8. Required: no `rsp_valid` from any of the three requests, `busy = 0` after the edge, and a new request to addr 12 returns `0x08000000`.
- Request addr `0x2`, then `0x1000` (with `DEPTH=1024`). Required: both return `rsp_err=1` and `rsp_instr=0`.
- Hold `load_en=1` writing `mem[5]=0xDEADBEEF` while `req_valid=1` for addr 20. Required: `req_ready=0` during the load, then the response is `0xDEADBEEF`.
- Pull `rst` low asynchronously between edges with 2 requests in flight. Required: `rsp_valid` and `busy` drop immediately, and after release memory still returns the previously loaded words.
